// File: rtl/hazard_unit_mc.sv
// Hazard controller for the 5-stage pipeline: load-use stalls with configurable latency,
// multi-cycle EX holds, taken-branch flushes and a saturating stall-cycle counter.
module hazard_unit_mc #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned MUL_LAT  = 4,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned PERF_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memread,
    input  logic              ex_mul_start,
    input  logic              branch_taken_ex,
    output logic              pc_hold,
    output logic              if_id_hold,
    output logic              id_ex_hold,
    output logic              bubble_ex,
    output logic              bubble_mem,
    output logic              flush_if_id,
    output logic              busy,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam logic [1:0] StIdle      = 2'd0;
    localparam logic [1:0] StLoadStall = 2'd1;
    localparam logic [1:0] StMulBusy   = 2'd2;

    // cnt holds the number of further stall-state cycles after the current one.
    // The detecting IDLE cycle already stalls, so LOAD_STALL covers LOAD_LAT-1 cycles and
    // MUL_BUSY covers MUL_LAT-2 cycles (the op's first EX cycle needs no hold).
    localparam logic [CNT_W-1:0] LoadInit = (LOAD_LAT > 1) ? CNT_W'(LOAD_LAT - 2) : '0;
    localparam logic [CNT_W-1:0] MulInit  = (MUL_LAT > 2) ? CNT_W'(MUL_LAT - 3) : '0;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PERF_W-1:0] stall_q, stall_d;
    logic              dep, lu;

    always_comb begin
        dep = (ex_rd != '0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
        lu  = ex_memread && dep;
    end

    always_comb begin
        pc_hold     = 1'b0;
        if_id_hold  = 1'b0;
        id_ex_hold  = 1'b0;
        bubble_ex   = 1'b0;
        bubble_mem  = 1'b0;
        flush_if_id = 1'b0;
        busy        = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;

        if (!rst) begin
            busy = (state_q != StIdle);
            case (state_q)
                StIdle: begin
                    if (branch_taken_ex) begin
                        flush_if_id = 1'b1;
                        bubble_ex   = 1'b1;
                    end else if (ex_mul_start && (MUL_LAT > 1)) begin
                        pc_hold    = 1'b1;
                        if_id_hold = 1'b1;
                        id_ex_hold = 1'b1;
                        bubble_mem = 1'b1;
                        if (MUL_LAT > 2) begin
                            state_d = StMulBusy;
                            cnt_d   = MulInit;
                        end
                    end else if (lu) begin
                        pc_hold    = 1'b1;
                        if_id_hold = 1'b1;
                        bubble_ex  = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = StLoadStall;
                            cnt_d   = LoadInit;
                        end
                    end
                end

                StLoadStall: begin
                    if (branch_taken_ex) begin
                        // Stall was for a wrong-path instruction; abandon it.
                        flush_if_id = 1'b1;
                        bubble_ex   = 1'b1;
                        state_d     = StIdle;
                        cnt_d       = '0;
                    end else begin
                        pc_hold    = 1'b1;
                        if_id_hold = 1'b1;
                        bubble_ex  = 1'b1;
                        if (cnt_q == '0) begin
                            state_d = StIdle;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end

                StMulBusy: begin
                    pc_hold    = 1'b1;
                    if_id_hold = 1'b1;
                    id_ex_hold = 1'b1;
                    bubble_mem = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end

                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (pc_hold && (stall_q != {PERF_W{1'b1}})) begin
            stall_d = stall_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench: dut_a (LOAD_LAT=1, MUL_LAT=4) runs a vector table; dut_b (LOAD_LAT=3,
// PERF_W=3) covers multi-cycle load stalls, wrong-path branch, saturation and mid-stall reset.
module tb_hazard_unit_mc;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_memread, ex_mul_start, branch_taken_ex;

    logic        ph_a, ih_a, eh_a, bx_a, bm_a, fl_a, busy_a;
    logic [31:0] stall_a;
    logic        ph_b, ih_b, eh_b, bx_b, bm_b, fl_b, busy_b;
    logic [2:0]  stall_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_unit_mc #(.REG_AW(5), .LOAD_LAT(1), .MUL_LAT(4), .CNT_W(4), .PERF_W(32)) dut_a (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_memread(ex_memread), .ex_mul_start(ex_mul_start),
        .branch_taken_ex(branch_taken_ex), .pc_hold(ph_a), .if_id_hold(ih_a),
        .id_ex_hold(eh_a), .bubble_ex(bx_a), .bubble_mem(bm_a), .flush_if_id(fl_a),
        .busy(busy_a), .stall_cycles(stall_a)
    );

    hazard_unit_mc #(.REG_AW(5), .LOAD_LAT(3), .MUL_LAT(4), .CNT_W(4), .PERF_W(3)) dut_b (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_memread(ex_memread), .ex_mul_start(ex_mul_start),
        .branch_taken_ex(branch_taken_ex), .pc_hold(ph_b), .if_id_hold(ih_b),
        .id_ex_hold(eh_b), .bubble_ex(bx_b), .bubble_mem(bm_b), .flush_if_id(fl_b),
        .busy(busy_b), .stall_cycles(stall_b)
    );

    // Output vector order: {pc_hold, if_id_hold, id_ex_hold, bubble_ex, bubble_mem, flush, busy}
    logic [6:0] out_a, out_b;
    assign out_a = {ph_a, ih_a, eh_a, bx_a, bm_a, fl_a, busy_a};
    assign out_b = {ph_b, ih_b, eh_b, bx_b, bm_b, fl_b, busy_b};

    typedef struct {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mem;
        logic       mul;
        logic       br;
        logic [6:0] exp;
        int         exp_stall;  // -1: not checked
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic mem, input logic mul, input logic br,
                                input logic [6:0] exp, input int st);
        vec_t v;
        v.rst = r; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
        v.mem = mem; v.mul = mul; v.br = br; v.exp = exp; v.exp_stall = st;
        return v;
    endfunction

    task automatic drive(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic mem, input logic mul, input logic br);
        @(posedge clk);
        #1;
        rst = r; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        ex_rd = rd; ex_memread = mem; ex_mul_start = mul; branch_taken_ex = br;
        #4;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_memread = 1'b0;
        ex_mul_start = 1'b0; branch_taken_ex = 1'b0;

        //            rst rs1 rs2 u1 u2 rd mem mul br  expected     stall
        vecs[0]  = mk(1, 5, 0, 1, 0, 5, 1, 0, 0, 7'b0000000, -1);  // reset with lu driven
        vecs[1]  = mk(1, 5, 0, 1, 0, 5, 1, 0, 0, 7'b0000000, 0);
        vecs[2]  = mk(0, 5, 0, 1, 0, 5, 1, 0, 0, 7'b1101000, 0);   // load-use rs1, 1 bubble
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 1);
        vecs[4]  = mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 7'b0000000, 1);   // x0 never a hazard
        vecs[5]  = mk(0, 7, 7, 0, 1, 7, 1, 0, 0, 7'b1101000, 1);   // load-use via rs2 only
        vecs[6]  = mk(0, 5, 0, 1, 0, 5, 1, 0, 1, 7'b0001010, 2);   // branch beats lu
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1110100, 2);   // mul start
        vecs[8]  = mk(0, 5, 0, 1, 0, 5, 1, 0, 1, 7'b1110101, 3);   // lu+branch ignored
        vecs[9]  = mk(0, 5, 0, 1, 0, 5, 1, 1, 0, 7'b1110101, 4);   // mul_start ignored
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 5);   // hold lasted 3 cycles
        vecs[11] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0000000, 5);   // rst masks outputs
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 0);

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rst, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2,
                  vecs[i].rd, vecs[i].mem, vecs[i].mul, vecs[i].br);
            chk($sformatf("vec%0d_outs", i), 32'(out_a), 32'(vecs[i].exp));
            if (vecs[i].exp_stall >= 0)
                chk($sformatf("vec%0d_stall", i), stall_a, vecs[i].exp_stall);
            if (i == 1) begin
                chk("rst_outs_b", 32'(out_b), 32'd0);
                chk("rst_stall_b", 32'(stall_b), 32'd0);
            end
        end

        // LOAD_LAT=3: load-use on rs2 stalls 3 consecutive cycles
        drive(0, 7, 7, 0, 1, 7, 1, 0, 0);
        chk("ll3_c1", 32'(out_b), 32'b1101000);
        chk("ll3_c1_stall", 32'(stall_b), 32'd0);
        drive(0, 7, 7, 0, 1, 7, 1, 0, 0);
        chk("ll3_c2", 32'(out_b), 32'b1101001);
        drive(0, 7, 7, 0, 1, 7, 1, 0, 0);
        chk("ll3_c3", 32'(out_b), 32'b1101001);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("ll3_done", 32'(out_b), 32'd0);
        chk("ll3_stall", 32'(stall_b), 32'd3);

        // Branch in the 2nd stall cycle abandons the stall
        drive(0, 5, 0, 1, 0, 5, 1, 0, 0);
        chk("wp_c1", 32'(out_b), 32'b1101000);
        drive(0, 5, 0, 1, 0, 5, 1, 0, 1);
        chk("wp_c2_flush", 32'(out_b), 32'b0001011);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("wp_c3_idle", 32'(out_b), 32'd0);
        chk("wp_stall", 32'(stall_b), 32'd4);

        // PERF_W=3 saturation: 9 back-to-back stall cycles from a cleared counter
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 9; c++) begin
            drive(0, 5, 0, 1, 0, 5, 1, 0, 0);
            chk($sformatf("sat_hold%0d", c), 32'(ph_b), 32'd1);
            chk($sformatf("sat_cnt%0d", c), 32'(stall_b), (c < 7) ? c : 7);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("sat_final", 32'(stall_b), 32'd7);

        // Reset in the middle of a load stall
        drive(0, 5, 0, 1, 0, 5, 1, 0, 0);
        chk("mr_c1", 32'(out_b), 32'b1101000);
        drive(1, 5, 0, 1, 0, 5, 1, 0, 0);
        chk("mr_rst_outs", 32'(out_b), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mr_idle", 32'(out_b), 32'd0);
        chk("mr_stall", 32'(stall_b), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
